// File: rtl/compute_unit_pkg.sv
// Shared types and helpers for the pipelined compute unit.
// Opcode encoding, flag bit positions and operand-field sizing.
// Imported by the ALU and the top level.
package compute_unit_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LOAD = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_NOT  = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_CMP  = 4'hA,
    OP_MOV  = 4'hB
  } opcode_e;

  // Bit positions inside out_flags
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  // The operand field must hold either two register ids or one immediate
  function automatic int opnd_w(input int rid_w, input int data_w);
    return (2 * rid_w > data_w) ? 2 * rid_w : data_w;
  endfunction

endpackage

// File: rtl/cu_alu.sv
// Combinational ALU for the compute unit: op + operands -> result and flags.
// Zero latency; purely combinational, no handshake of its own.
// Also reports whether the op writes the regfile, updates flags, or is illegal.
module cu_alu
  import compute_unit_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              writes,
  output logic              updates_flags,
  output logic              illegal
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Decode the opcode into a result and its side effects
  always_comb begin
    result        = '0;
    carry         = 1'b0;
    writes        = 1'b0;
    updates_flags = 1'b0;
    illegal       = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LOAD: begin
        result = imm;
        writes = 1'b1;
      end
      OP_ADD: begin
        {carry, result} = sum_ext;
        writes          = 1'b1;
        updates_flags   = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // Top bit of the extended difference is the borrow (a < b)
        {carry, result} = diff_ext;
        writes          = (op == OP_SUB);
        updates_flags   = 1'b1;
      end
      OP_AND: begin
        result        = a & b;
        writes        = 1'b1;
        updates_flags = 1'b1;
      end
      OP_OR: begin
        result        = a | b;
        writes        = 1'b1;
        updates_flags = 1'b1;
      end
      OP_NOT: begin
        result        = ~a;
        writes        = 1'b1;
        updates_flags = 1'b1;
      end
      OP_XOR: begin
        result        = a ^ b;
        writes        = 1'b1;
        updates_flags = 1'b1;
      end
      OP_SHL: begin
        result        = {a[DATA_W-2:0], 1'b0};
        carry         = a[DATA_W-1];
        writes        = 1'b1;
        updates_flags = 1'b1;
      end
      OP_SHR: begin
        result        = {1'b0, a[DATA_W-1:1]};
        carry         = a[0];
        writes        = 1'b1;
        updates_flags = 1'b1;
      end
      OP_MOV: begin
        result = a;
        writes = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/compute_unit_pipe.sv
// Compute unit: executes one instruction per accepted beat against a regfile.
// Latency 1 cycle from accept to out_valid; throughput 1/cycle.
// in_ready drops only while a result is held and out_ready is low.
module compute_unit_pipe
  import compute_unit_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 16
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          in_valid,
  output logic                                                          in_ready,
  input  logic [4+$clog2(NUM_REGS)+opnd_w($clog2(NUM_REGS),DATA_W)-1:0] in_instr,
  output logic                                                          out_valid,
  input  logic                                                          out_ready,
  output logic [DATA_W-1:0]                                             out_data,
  output logic [$clog2(NUM_REGS)-1:0]                                   out_tgt,
  output logic [1:0]                                                    out_flags,
  output logic                                                          out_err,
  input  logic [$clog2(NUM_REGS)-1:0]                                   dbg_addr,
  output logic [DATA_W-1:0]                                             dbg_data,
  output logic [CNT_W-1:0]                                              retired
);

  localparam int RID_W   = $clog2(NUM_REGS);
  localparam int OPND_W  = opnd_w(RID_W, DATA_W);
  localparam int INSTR_W = 4 + RID_W + OPND_W;

  // Instruction fields
  logic [3:0]        opc;
  logic [RID_W-1:0]  tgt;
  logic [OPND_W-1:0] opnd;
  logic [RID_W-1:0]  src0;
  logic [RID_W-1:0]  src1;
  logic [DATA_W-1:0] imm;

  assign opc  = in_instr[INSTR_W-1 -: 4];
  assign tgt  = in_instr[OPND_W +: RID_W];
  assign opnd = in_instr[OPND_W-1:0];
  assign src0 = opnd[2*RID_W-1:RID_W];
  assign src1 = opnd[RID_W-1:0];
  assign imm  = opnd[DATA_W-1:0];

  // State
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [RID_W-1:0]  out_tgt_q, out_tgt_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic accept;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_writes;
  logic              alu_upd;
  logic              alu_illegal;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operands come from pre-edge register values, so tgt==src is safe
  cu_alu #(.DATA_W(DATA_W)) u_alu (
    .op            (opc),
    .a             (regs_q[src0]),
    .b             (regs_q[src1]),
    .imm           (imm),
    .result        (alu_result),
    .carry         (alu_carry),
    .zero          (alu_zero),
    .writes        (alu_writes),
    .updates_flags (alu_upd),
    .illegal       (alu_illegal)
  );

  // Next-state: retire on accept, otherwise drain the output when consumed
  always_comb begin
    regs_d      = regs_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tgt_d   = out_tgt_q;
    out_err_d   = out_err_q;
    retired_d   = retired_q;
    if (accept) begin
      if (alu_writes) begin
        regs_d[tgt] = alu_result;
      end
      if (alu_upd) begin
        carry_d = alu_carry;
        zero_d  = alu_zero;
      end
      out_valid_d = 1'b1;
      out_data_d  = alu_result;
      out_tgt_d   = tgt;
      out_err_d   = alu_illegal;
      retired_d   = retired_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tgt_q   <= '0;
      out_err_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      regs_q      <= regs_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tgt_q   <= out_tgt_d;
      out_err_q   <= out_err_d;
      retired_q   <= retired_d;
    end
  end

  // The flag registers only change on retire, so they always hold the
  // post-instruction state of the beat being presented
  always_comb begin
    out_flags         = '0;
    out_flags[FLAG_C] = carry_q;
    out_flags[FLAG_Z] = zero_q;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tgt   = out_tgt_q;
  assign out_err   = out_err_q;
  assign retired   = retired_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_compute_unit_pipe.sv
// Directed testbench for compute_unit_pipe at default parameters.
module tb_compute_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_tgt;
  logic [1:0]  out_flags;
  logic        out_err;
  logic [3:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  compute_unit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tgt   (out_tgt),
    .out_flags (out_flags),
    .out_err   (out_err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] tgt,
                                     input logic [7:0] opnd);
    return {op, tgt, opnd};
  endfunction

  // Present one beat for one clock edge, then sample #1 after the edge
  task automatic issue(input logic [15:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    checks++; if ({out_data, out_tgt, out_flags, out_err} !== 15'd0) begin errors++; $display("FAIL reset_outs got %h/%h/%b/%b want 0", out_data, out_tgt, out_flags, out_err); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    issue(mk(4'h1, 4'd2, 8'h05));
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h05 || out_tgt !== 4'd2) begin errors++; $display("FAIL load_r2 got v=%0b d=%h t=%0d want v=1 d=05 t=2", out_valid, out_data, out_tgt); end
    issue(mk(4'h1, 4'd3, 8'h03));
    checks++; if (out_data !== 8'h03 || out_tgt !== 4'd3) begin errors++; $display("FAIL load_r3 got d=%h t=%0d want d=03 t=3", out_data, out_tgt); end
    issue(mk(4'h2, 4'd4, 8'h23));
    checks++; if (out_data !== 8'h08 || out_tgt !== 4'd4) begin errors++; $display("FAIL add_r4 got d=%h t=%0d want d=08 t=4", out_data, out_tgt); end
    checks++; if (out_flags !== 2'b00) begin errors++; $display("FAIL add_r4_flags got %b want 00", out_flags); end
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL basic_retired got %0d want 3", retired); end
  endtask

  task automatic test_carry();
    issue(mk(4'h1, 4'd1, 8'hFF));
    issue(mk(4'h1, 4'd2, 8'h01));
    issue(mk(4'h2, 4'd5, 8'h12));
    checks++; if (out_data !== 8'h00 || out_flags !== 2'b11) begin errors++; $display("FAIL add_wrap got d=%h f=%b want d=00 f=11", out_data, out_flags); end
    issue(mk(4'h3, 4'd6, 8'h21));
    checks++; if (out_data !== 8'h02 || out_flags !== 2'b10) begin errors++; $display("FAIL sub_borrow got d=%h f=%b want d=02 f=10", out_data, out_flags); end
    dbg_addr = 4'd6;
    #1;
    checks++; if (dbg_data !== 8'h02) begin errors++; $display("FAIL sub_write got %h want 02", dbg_data); end
  endtask

  task automatic test_backpressure();
    logic [15:0] q [3];
    q[0] = mk(4'h1, 4'd8, 8'h22);
    q[1] = mk(4'h1, 4'd9, 8'h33);
    q[2] = mk(4'h1, 4'd10, 8'h44);
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", out_valid); end
    out_ready = 1'b0;
    issue(mk(4'h1, 4'd7, 8'h11));
    in_valid = 1'b1;
    in_instr = q[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11 || out_tgt !== 4'd7 || retired !== 16'd8) begin
        errors++; $display("FAIL stall_%0d got rdy=%0b v=%0b d=%h t=%0d ret=%0d want rdy=0 v=1 d=11 t=7 ret=8", i, in_ready, out_valid, out_data, out_tgt, retired);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = q[i];
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== q[i][7:0] || out_tgt !== q[i][11:8] || retired !== 16'(9 + i)) begin
        errors++; $display("FAIL release_%0d got v=%0b d=%h t=%0d ret=%0d want v=1 d=%h t=%0d ret=%0d", i, out_valid, out_data, out_tgt, retired, q[i][7:0], q[i][11:8], 9 + i);
      end
    end
    idle_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_shift_cmp();
    issue(mk(4'h1, 4'd1, 8'h81));
    issue(mk(4'h8, 4'd2, 8'h10));
    checks++; if (out_data !== 8'h02 || out_flags !== 2'b10) begin errors++; $display("FAIL shl got d=%h f=%b want d=02 f=10", out_data, out_flags); end
    issue(mk(4'h9, 4'd3, 8'h10));
    checks++; if (out_data !== 8'h40 || out_flags !== 2'b10) begin errors++; $display("FAIL shr got d=%h f=%b want d=40 f=10", out_data, out_flags); end
    issue(mk(4'hA, 4'd2, 8'h22));
    checks++; if (out_data !== 8'h00 || out_flags !== 2'b01) begin errors++; $display("FAIL cmp got d=%h f=%b want d=00 f=01", out_data, out_flags); end
    dbg_addr = 4'd2;
    #1;
    checks++; if (dbg_data !== 8'h02) begin errors++; $display("FAIL cmp_nowrite got %h want 02", dbg_data); end
    checks++; if (retired !== 16'd15) begin errors++; $display("FAIL shift_retired got %0d want 15", retired); end
  endtask

  task automatic test_illegal();
    issue(mk(4'hE, 4'd3, 8'h12));
    checks++; if (out_err !== 1'b1 || out_data !== 8'h00) begin errors++; $display("FAIL illegal got err=%0b d=%h want err=1 d=00", out_err, out_data); end
    checks++; if (out_flags !== 2'b01) begin errors++; $display("FAIL illegal_flags got %b want 01", out_flags); end
    checks++; if (retired !== 16'd16) begin errors++; $display("FAIL illegal_retired got %0d want 16", retired); end
    dbg_addr = 4'd3;
    #1;
    checks++; if (dbg_data !== 8'h40) begin errors++; $display("FAIL illegal_nowrite got %h want 40", dbg_data); end
  endtask

  task automatic test_self_operand();
    dbg_addr = 4'd1;
    in_valid = 1'b1;
    in_instr = mk(4'h2, 4'd1, 8'h11);
    #1;
    checks++; if (dbg_data !== 8'h81) begin errors++; $display("FAIL self_pre got %h want 81", dbg_data); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_data !== 8'h02 || out_flags !== 2'b10 || out_err !== 1'b0) begin errors++; $display("FAIL self_add got d=%h f=%b e=%0b want d=02 f=10 e=0", out_data, out_flags, out_err); end
    checks++; if (dbg_data !== 8'h02) begin errors++; $display("FAIL self_post got %h want 02", dbg_data); end
    issue(mk(4'hB, 4'd11, 8'h30));
    dbg_addr = 4'd11;
    #1;
    checks++; if (out_data !== 8'h40 || dbg_data !== 8'h40 || out_flags !== 2'b10) begin errors++; $display("FAIL mov got d=%h r=%h f=%b want d=40 r=40 f=10", out_data, dbg_data, out_flags); end
  endtask

  task automatic test_async_reset();
    issue(mk(4'h1, 4'd5, 8'h55));
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin errors++; $display("FAIL pre_reset got v=%0b d=%h want v=1 d=55", out_valid, out_data); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || retired !== 16'd0 || out_data !== 8'h00) begin errors++; $display("FAIL async_reset got v=%0b ret=%0d d=%h want v=0 ret=0 d=00", out_valid, retired, out_data); end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      checks++; if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", i, dbg_data); end
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    dbg_addr  = '0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_shift_cmp();
    test_illegal();
    test_self_operand();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
